async_fifo: RTL and testbench

Dual-clock first-in/first-out buffer that carries DATA_WIDTH-bit words from a write clock domain to an unrelated read clock domain. It sits on every clock-domain crossing in the multi-clock system where a data stream must cross safely. Gray-coded pointers cross through flop synchronizers, and each domain has its own FULL or EMPTY status flag.

---
 rtl/async_fifo_pkg.sv | 20 ++
 rtl/async_fifo_ptr_sync.sv | 36 +++
 rtl/async_fifo.sv | 124 ++++++++++++
 tb/tb_async_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the dual-clock FIFO.
// Build option: define ASYNC_FIFO_SYNC3_EN for 3-stage pointer synchronizers
// (default is 2 stages).
package async_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR       = 3;

`ifdef ASYNC_FIFO_SYNC3_EN
    localparam int unsigned SYNC_STAGES = 3;
`else
    localparam int unsigned SYNC_STAGES = 2;
`endif

    // Binary to reflected Gray code; callers truncate to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded FIFO pointer entering another
// clock domain. Depth comes from the instantiating FIFO.
module fifo_ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ptr_in,
    output logic [WIDTH-1:0] ptr_out
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;

    // Shift the incoming pointer one stage deeper each clock.
    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = ptr_in;
        for (int unsigned i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // Synchronizer flops, cleared by the destination-domain reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign ptr_out = chain_q[STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO: Gray-coded pointers cross domains through fifo_ptr_sync;
// FULL lives in the write domain, EMPTY in the read domain. RD_DATA is
// show-ahead (head word visible whenever EMPTY is low).
// Build option: ASYNC_FIFO_SYNC3_EN selects 3-stage synchronizers.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR       = DEF_ADDR
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY
);

    localparam int unsigned PTR_W = ADDR + 1;
    localparam int unsigned DEPTH = 2 ** ADDR;

    // Write-domain state
    logic [PTR_W-1:0]      wbin_q, wbin_d;
    logic [PTR_W-1:0]      wgray_q, wgray_d;
    logic [PTR_W-1:0]      wq_rgray;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  w_en_c;
    logic [ADDR-1:0]       waddr_c;
    logic [PTR_W-1:0]      full_cmp_c;

    // Read-domain state
    logic [PTR_W-1:0]      rbin_q, rbin_d;
    logic [PTR_W-1:0]      rgray_q, rgray_d;
    logic [PTR_W-1:0]      rq_wgray;
    logic                  r_en_c;
    logic [ADDR-1:0]       raddr_c;

    // FULL: write pointer one lap ahead of the synchronized read pointer,
    // which in Gray form means the top two bits inverted, the rest equal.
    assign full_cmp_c = {~wq_rgray[ADDR -: 2], wq_rgray[ADDR-2:0]};
    assign FULL       = (wgray_q == full_cmp_c);
    assign w_en_c     = W_INC & ~FULL;
    assign waddr_c    = wbin_q[ADDR-1:0];

    // Next write pointer and memory contents; a write while FULL is dropped.
    always_comb begin
        wbin_d  = wbin_q;
        mem_d   = mem_q;
        if (w_en_c) begin
            wbin_d          = wbin_q + PTR_W'(1);
            mem_d[waddr_c]  = WR_DATA;
        end
        wgray_d = PTR_W'(bin2gray(32'(wbin_d)));
    end

    // Write-domain registers, including the storage array.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            mem_q   <= mem_d;
        end
    end

    // EMPTY: read pointer has caught up with the synchronized write pointer.
    assign EMPTY   = (rgray_q == rq_wgray);
    assign r_en_c  = R_INC & ~EMPTY;
    assign raddr_c = rbin_q[ADDR-1:0];
    assign RD_DATA = mem_q[raddr_c];

    // Next read pointer; a pop while EMPTY is ignored.
    always_comb begin
        rbin_d = rbin_q;
        if (r_en_c) begin
            rbin_d = rbin_q + PTR_W'(1);
        end
        rgray_d = PTR_W'(bin2gray(32'(rbin_d)));
    end

    // Read-domain pointer registers.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin_q  <= '0;
            rgray_q <= '0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
        end
    end

    // Read pointer into the write domain (for FULL).
    fifo_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk     (W_CLK),
        .rst_n   (W_RST),
        .ptr_in  (rgray_q),
        .ptr_out (wq_rgray)
    );

    // Write pointer into the read domain (for EMPTY).
    fifo_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk     (R_CLK),
        .rst_n   (R_RST),
        .ptr_in  (wgray_q),
        .ptr_out (rq_wgray)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: W_CLK period 10, R_CLK period 24 (edges
// never coincide). Expected data and flag latencies are hand-derived.
module tb_async_fifo;
    import async_fifo_pkg::*;

    logic       w_clk = 1'b0;
    logic       r_clk = 1'b0;
    logic       w_rst = 1'b0;
    logic       r_rst = 1'b0;
    logic       w_inc = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       r_inc = 1'b0;
    logic [7:0] rd_data;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] words [24];

    always #5  w_clk = ~w_clk;
    always #12 r_clk = ~r_clk;

    async_fifo dut (
        .W_CLK   (w_clk),
        .W_RST   (w_rst),
        .R_CLK   (r_clk),
        .R_RST   (r_rst),
        .W_INC   (w_inc),
        .WR_DATA (wr_data),
        .FULL    (full),
        .R_INC   (r_inc),
        .RD_DATA (rd_data),
        .EMPTY   (empty)
    );

    // Single comparison point: count, report mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until EMPTY is low; leaves us #1 after an R_CLK edge.
    task automatic wait_not_empty(input string tag);
        for (int k = 0; k < 20; k++) begin
            @(posedge r_clk); #1;
            if (!empty) break;
        end
        chk(tag, 32'(empty), 32'd0);
    endtask

    // One pop, starting #1 after an R_CLK edge.
    task automatic pop1();
        r_inc = 1'b1;
        @(posedge r_clk); #1;
        r_inc = 1'b0;
    endtask

    initial begin
        int cnt;
        int wi;
        int rj;

        // ---- reset with clocks running
        repeat (3) @(posedge w_clk);
        @(negedge r_clk);
        w_rst = 1'b1;
        r_rst = 1'b1;
        @(posedge r_clk); #1;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        pop1();
        pop1();
        chk("pop_on_empty", 32'(empty), 32'd1);

        // ---- single write, EMPTY latency, show-ahead data
        @(posedge w_clk); #1;
        w_inc = 1'b1;
        wr_data = 8'h5A;
        @(posedge w_clk);
        fork begin #1; w_inc = 1'b0; end join_none
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge r_clk); #1;
            cnt++;
            if (!empty) break;
        end
        chk("wr_to_empty_lat", 32'(cnt), 32'(SYNC_STAGES));
        chk("show_ahead_5a", 32'(rd_data), 32'h5A);
        pop1();
        chk("empty_after_pop", 32'(empty), 32'd1);

        // ---- fill to FULL, dropped 9th write, ordered drain
        @(posedge w_clk); #1;
        for (int i = 0; i < 8; i++) begin
            w_inc = 1'b1;
            wr_data = 8'(8'h10 + i);
            @(posedge w_clk); #1;
            if (i == 6) chk("full_after_7", 32'(full), 32'd0);
        end
        chk("full_after_8", 32'(full), 32'd1);
        wr_data = 8'hFF;
        @(posedge w_clk); #1;
        w_inc = 1'b0;
        chk("full_after_9th", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            wait_not_empty("drain_wait");
            chk($sformatf("drain_%0d", i), 32'(rd_data), 32'(8'h10 + i));
            pop1();
        end
        repeat (6) @(posedge r_clk);
        #1;
        chk("empty_after_drain", 32'(empty), 32'd1);

        // ---- 24-word stream across three wraps
        for (int i = 0; i < 24; i++) words[i] = 8'($urandom);
        wi = 0;
        rj = 0;
        fork
            begin
                for (int k = 0; k < 600 && wi < 24; k++) begin
                    @(posedge w_clk); #1;
                    if (!full) begin
                        w_inc = 1'b1;
                        wr_data = words[wi];
                        wi++;
                    end else begin
                        w_inc = 1'b0;
                    end
                end
                @(posedge w_clk); #1;
                w_inc = 1'b0;
            end
            begin
                @(posedge r_clk); #1;
                r_inc = 1'b1;
                for (int k = 0; k < 300 && rj < 24; k++) begin
                    @(negedge r_clk);
                    if (!empty) begin
                        chk($sformatf("stream_%0d", rj), 32'(rd_data), 32'(words[rj]));
                        rj++;
                    end
                end
                @(posedge r_clk); #1;
                r_inc = 1'b0;
            end
        join
        chk("stream_wr_done", 32'(wi), 32'd24);
        chk("stream_rd_done", 32'(rj), 32'd24);
        repeat (6) @(posedge r_clk);
        #1;
        chk("empty_after_stream", 32'(empty), 32'd1);

        // ---- one pop while FULL: FULL release latency
        @(posedge w_clk); #1;
        for (int i = 0; i < 8; i++) begin
            w_inc = 1'b1;
            wr_data = 8'(8'h30 + i);
            @(posedge w_clk); #1;
        end
        w_inc = 1'b0;
        chk("full_before_pop", 32'(full), 32'd1);
        wait_not_empty("full_pop_wait");
        chk("head_30", 32'(rd_data), 32'h30);
        r_inc = 1'b1;
        @(posedge r_clk);
        fork begin #1; r_inc = 1'b0; end join_none
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge w_clk); #1;
            cnt++;
            if (!full) break;
        end
        chk("pop_to_full_lat", 32'(cnt), 32'(SYNC_STAGES));

        // ---- leave 5 queued, then flush with both resets
        wait_not_empty("pre_flush_wait");
        chk("head_31", 32'(rd_data), 32'h31);
        pop1();
        pop1();
        chk("head_33", 32'(rd_data), 32'h33);
        #3;
        w_rst = 1'b0;
        r_rst = 1'b0;
        #1;
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_full", 32'(full), 32'd0);
        chk("flush_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge r_clk);
        @(negedge r_clk);
        w_rst = 1'b1;
        r_rst = 1'b1;
        @(posedge w_clk); #1;
        for (int i = 0; i < 3; i++) begin
            w_inc = 1'b1;
            wr_data = 8'(8'h61 + i);
            @(posedge w_clk); #1;
        end
        w_inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_not_empty("post_flush_wait");
            chk($sformatf("post_flush_%0d", i), 32'(rd_data), 32'(8'h61 + i));
            pop1();
        end
        repeat (6) @(posedge r_clk);
        #1;
        chk("empty_end", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
